// File: rtl/timer_pkg.sv
// Shared definitions for the programmable down-counter timer.
// State encoding, register offsets, CTRL bit positions and mode codes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_irq.sv
// Memory-mapped down-counter timer driving one CP0 HWInt line.
// One-shot (held level) or auto-reload (one-cycle pulse) interrupts.
module timer_irq
  import timer_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t               state;
  state_t               stateNext;
  logic [3:0]           ctrl;
  logic [3:0]           ctrlNext;
  logic [TIMER_W-1:0]   preset;
  logic [TIMER_W-1:0]   count;
  logic [TIMER_W-1:0]   countNext;
  logic                 pending;
  logic                 pendNext;

  logic ctrlWr;
  logic presetWr;
  logic en;
  logic reload;
  logic stop;
  logic countLow;
  logic setPend;

  assign ctrlWr   = we && (addr == ADDR_CTRL);
  assign presetWr = we && (addr == ADDR_PRESET);
  assign en       = ctrl[CTRL_EN];
  assign reload   =
    ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
  assign stop     = ctrlWr && !wdata[CTRL_EN];
  assign countLow = count <= TIMER_W'(1);

  // Pending set outranks a same-edge CTRL write clear.
  assign setPend =
    (state == CNT && en && countLow && !stop) ||
    (state == INT && !reload);

  always_comb begin
    stateNext = state;
    countNext = count;
    ctrlNext  = ctrl;
    pendNext  = pending;
    unique case (state)
      IDLE: begin
        if (en) stateNext = LOAD;
      end
      LOAD: begin
        countNext = preset;
        stateNext = CNT;
      end
      CNT: begin
        if (!en) begin
          stateNext = IDLE;
        end else if (countLow) begin
          countNext = '0;
          stateNext = INT;
        end else begin
          countNext = count - TIMER_W'(1);
        end
      end
      INT: begin
        if (reload) begin
          stateNext = LOAD;
        end else begin
          stateNext         = IDLE;
          ctrlNext[CTRL_EN] = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (ctrlWr) ctrlNext = wdata[3:0];
    if (stop) begin
      stateNext = IDLE;
      countNext = count;
    end
    if (setPend)     pendNext = 1'b1;
    else if (ctrlWr) pendNext = 1'b0;
    else if (reload) pendNext = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= stateNext;
      ctrl    <= ctrlNext;
      count   <= countNext;
      pending <= pendNext;
      if (presetWr) preset <= wdata[TIMER_W-1:0];
    end
  end

  assign irq = pending & ctrl[CTRL_IM];

  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_CTRL:   rdata = {28'b0, ctrl};
      ADDR_PRESET: rdata = 32'(preset);
      ADDR_COUNT:  rdata = 32'(count);
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq.
// Expected COUNT/irq come from closed-form period arithmetic.
module tb_timer_irq;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int nCmp = 0;
  int nBad = 0;

  timer_irq #(.TIMER_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Called between negedge and posedge; returns after the next negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // k = edges since the enabling CTRL write; model from period math.
  task automatic trial(input int p, input logic [3:0] c, input int n);
    int pe;
    int t;
    int m;
    int ec;
    int ei;
    bit rl;
    logic [31:0] v;
    pe = (p < 1) ? 1 : p;
    t  = pe + 2;
    rl = (c[2:1] == 2'b01);
    wr(ADDR_PRESET, p);
    wr(ADDR_CTRL, {28'b0, c});
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      rd(ADDR_COUNT, v);
      if (k < 2) begin
        ec = -1;
        ei = 0;
      end else if (!rl && k >= pe + 2) begin
        ec = 0;
        ei = int'(c[3]);
      end else begin
        m  = (k - 2) % t;
        ec = (m < pe) ? p - m : 0;
        ei = (m == pe) ? int'(c[3]) : 0;
      end
      if (ec >= 0) check("count", v, ec);
      check("irq", {31'b0, irq}, ei);
    end
    rd(ADDR_CTRL, v);
    check("ctrlEnd", v,
          rl ? {28'b0, c} : {28'b0, c[3:1], 1'b0});
    wr(ADDR_CTRL, 32'd0);
    check("irqStop", {31'b0, irq}, 0);
  endtask

  initial begin
    logic [31:0] v;
    logic [3:0]  c;

    // Reset held with bus activity
    repeat (4) begin
      addr  = ADDR_CTRL;
      wdata = 32'hFFFF_FFFF;
      we    = ~we;
      @(negedge clk);
    end
    we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check("rstHeld", v, 0);
    end
    check("rstIrq", {31'b0, irq}, 0);
    reset = 1'b1;
    step(1);
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      check("rstRel", v, 0);
    end

    // Directed cases through the same model
    trial(5, 4'h9, 12);
    trial(3, 4'hB, 24);
    trial(2, 4'h1, 10);
    trial(0, 4'h9, 8);
    trial(0, 4'hB, 14);

    // Randomized mode/mask/preset
    for (int i = 0; i < 12; i++) begin
      int p;
      p = int'($urandom_range(0, 7));
      c = {1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'b1};
      trial(p, c, 3 * ((p < 1 ? 1 : p) + 2) + 4);
    end

    // PRESET rewrite mid-count, then freeze
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h3);
    step(4);
    rd(ADDR_COUNT, v);
    check("midK4", v, 8);
    wr(ADDR_PRESET, 32'd100);
    rd(ADDR_COUNT, v);
    check("midK5", v, 7);
    step(9);
    rd(ADDR_COUNT, v);
    check("reload100", v, 100);
    wr(ADDR_CTRL, 32'h2);
    rd(ADDR_COUNT, v);
    check("freeze0", v, 100);
    step(3);
    rd(ADDR_COUNT, v);
    check("freeze3", v, 100);
    check("freezeIrq", {31'b0, irq}, 0);
    wr(ADDR_COUNT, 32'd5);
    wr(2'd3, 32'd7);
    rd(ADDR_COUNT, v);
    check("cntRO", v, 100);
    rd(2'd3, v);
    check("addr3", v, 0);

    // CTRL write on the INT edge: pending set wins
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    step(4);
    check("intIrq", {31'b0, irq}, 1);
    wr(ADDR_CTRL, 32'h8);
    check("conflictIrq", {31'b0, irq}, 1);
    rd(ADDR_CTRL, v);
    check("conflictCtrl", v, 8);
    wr(ADDR_CTRL, 32'h8);
    check("ackIrq", {31'b0, irq}, 0);

    // Async reset with irq held high
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h9);
    step(6);
    check("heldIrq", {31'b0, irq}, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arstIrq", {31'b0, irq}, 0);
    rd(ADDR_PRESET, v);
    check("arstPreset", v, 0);
    rd(ADDR_CTRL, v);
    check("arstCtrl", v, 0);
    @(negedge clk);
    reset = 1'b1;

    // Async reset mid-count
    wr(ADDR_PRESET, 32'd6);
    wr(ADDR_CTRL, 32'hB);
    step(3);
    rd(ADDR_COUNT, v);
    check("preArst", v, 5);
    #1;
    reset = 1'b0;
    #1;
    rd(ADDR_COUNT, v);
    check("arstCount", v, 0);
    check("arstIrq2", {31'b0, irq}, 0);
    @(negedge clk);
    reset = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
Name: timer_irq

Overview:
- Memory-mapped programmable down-counter timer that raises a hardware interrupt line.
- Sits upstream of the CP0 coprocessor: `irq` drives one bit of CP0's 6-bit HWInt input, which CP0 latches into Cause.IP.
- Software programs it through a three-word register window (CTRL, PRESET, COUNT) on the data bus.
- Two modes: one-shot (level interrupt held until software acknowledges) and auto-reload (one-cycle interrupt pulse per period).

Parameters:
- TIMER_W, 32, width of PRESET and COUNT registers (legal range 2..32).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- addr  in  2  word offset within timer window: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  in  1  write strobe; write takes effect at the rising edge where we=1.
- wdata  in  32  write data.
- rdata  out  32  combinational read data for `addr`.
- irq  out  1  interrupt request to CP0 HWInt bit.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - CTRL=0, PRESET=0, COUNT=0.
  - state=IDLE, pending=0, irq=0.
- CTRL bit layout:
  - [0] EN (count enable).
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 00.
  - [3] IM (interrupt mask; 1 = irq allowed).
  - [31:4] are not stored and read as 0.
- Reads:
  - addr0 gives {28'b0, CTRL[3:0]}.
  - addr1 gives PRESET and addr2 gives COUNT, each zero-extended to 32 bits.
  - addr3 reads 0.
- Writes:
  - addr0 updates CTRL[3:0].
  - addr1 updates PRESET[TIMER_W-1:0]; upper bits are ignored.
  - addr2 and addr3 writes are ignored. COUNT is never software-writable.
- States: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - if EN=0, go to IDLE (COUNT holds its value);
    - else if COUNT<=1, COUNT<=0 and go to INT;
    - else COUNT<=COUNT-1.
  - INT: pending<=1.
    - MODE=01: go to LOAD.
    - one-shot: hardware clears CTRL.EN and goes to IDLE.
- Interrupt output:
  - irq = pending & IM. It is registered logic, with no combinational path from bus inputs.
  - One-shot: pending stays 1 until any write to CTRL, which clears it on that edge.
  - Auto-reload: pending clears automatically one cycle after being set, giving a 1-cycle irq pulse per period. A CTRL write also clears it.
- Timing:
  - Enable write at edge E → LOAD at E+1 → COUNT=PRESET at E+2.
  - First pending=1 at edge E+max(PRESET,1)+2.
  - Auto-reload period is max(PRESET,1)+2 cycles.
- PRESET=0 behaves as PRESET=1 (minimum period); COUNT does not wrap.
- A PRESET write while counting does not disturb COUNT; it is used at the next LOAD.
- Simultaneous events:
  - A CTRL write in the same cycle as the hardware EN clear in INT: the bus write wins for CTRL, and pending still sets (INT action), then is cleared by the write only on a later CTRL write.
  - In other words, on a same-edge conflict, pending set has priority over write-clear.
  - A CTRL write with EN=0 in any state forces next state to IDLE at that edge's successor.
- Reset mid-count: all state returns immediately to reset values; irq drops asynchronously.

Decomposition:
- Shared package `timer_pkg` holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, CNT=2'd2, INT=2'd3);
  - register offsets (ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2);
  - CTRL bit indices (CTRL_EN=0, CTRL_MODE_LO=1, CTRL_MODE_HI=2, CTRL_IM=3);
  - mode codes (MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01).
- Single module, no sub-module: the register file and FSM are too small to split usefully.

Test Plan:
- Reset: hold reset=0 with we pulses toggling → all reads return 0, irq=0. Release, then read CTRL/PRESET/COUNT → 0.
- One-shot, PRESET=5:
  - Stimulus: write PRESET=5, then CTRL=0x9 (EN|IM) at edge E.
  - Required: COUNT reads 5,4,3,2,1 on successive cycles from E+2; irq rises after edge E+7 and stays high; CTRL reads 0x8.
  - Acknowledge: writing CTRL=0x8 drops irq the next cycle.
- Auto-reload, PRESET=3, CTRL=0xB:
  - irq is a 1-cycle pulse every 5 cycles for at least 4 periods.
  - COUNT never reads above 3 or wraps.
- Mask and edges:
  - CTRL=0x1 (IM=0) with PRESET=2: irq stays 0 while state still reaches INT; EN reads 0 afterwards.
  - PRESET=0: behaves exactly like PRESET=1 (irq at E+3).
- Mid-operation changes:
  - Writing PRESET=100 during a count of 10 does not change the current COUNT sequence; the next reload starts at 100.
  - Writing CTRL EN=0 mid-count freezes COUNT and stops irq.
  - Asserting reset=0 mid-count zeroes all registers and irq immediately (asynchronously).
- Reads of addr3 return 0; writes to addr2/addr3 have no effect on COUNT.
